// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state type, read-word layout and row/column helpers for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, CONFIRM, HOLD, RELEASE} kp_state_e;

  localparam int CODE_LSB  = 0;
  localparam int VALID_BIT = 8;
  localparam int OVR_BIT   = 9;

  localparam logic [11:0] KEYADDR_DEFAULT = 12'h010;

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  function automatic logic one_low(input logic [3:0] col);
    return $countones(~col) == 1;
  endfunction

  // Only meaningful when one_low() holds for the same pattern.
  function automatic logic [1:0] low_index(input logic [3:0] col);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (!col[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// rtl/keypad_col_sync.sv - two-flop synchronizer for the asynchronous keypad columns
module keypad_col_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_async,
  output logic [3:0] col_sync
);

  logic [3:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      meta     <= col_async;
      col_sync <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scan/debounce with a polled key word; KEYPAD_REPEAT_EN adds auto-repeat while held
module keypad_scanner import keypad_pkg::*; #(
  parameter logic [11:0] KEYADDR  = KEYADDR_DEFAULT,
  parameter int          SCAN_CYC = 1000,
  parameter int          DEB_CYC  = 200000
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int          REPEAT_DLY = 50000000,
  parameter int          REPEAT_PER = 10000000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_ena,
  input  logic [11:0] dv_addr,
  input  logic [3:0]  key_col,
  output logic [3:0]  key_row,
  output logic [31:0] rd_data
);

  localparam int SW = $clog2(SCAN_CYC);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYC - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);

  kp_state_e     state;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] deb_cnt;
  logic [1:0]    row_idx;
  logic [3:0]    col_s;
  logic [3:0]    pattern;
  logic [3:0]    cand;
  logic [3:0]    code;
  logic          valid;
  logic          overrun;
  logic          rd_sel;
  logic          latch_now;
  logic [31:0]   rd_word;

  keypad_col_sync u_col_sync (
    .clk       (clk),
    .rst       (rst),
    .col_async (key_col),
    .col_sync  (col_s)
  );

  assign rd_sel = rd_ena && (dv_addr == KEYADDR);

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_first;
  logic          rep_hit;

  assign rep_hit = (rep_cnt == (rep_first ? RW'(REPEAT_DLY - 1) : RW'(REPEAT_PER - 1)));

  // Any exit from HOLD rearms the long initial delay.
  always_ff @(posedge clk) begin
    if (rst || state != HOLD) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (rep_hit) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    latch_now = 1'b0;
    if (state == CONFIRM && col_s == pattern && deb_cnt == DEB_LAST) latch_now = 1'b1;
`ifdef KEYPAD_REPEAT_EN
    if (state == HOLD && col_s != 4'hF && rep_hit) latch_now = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SCAN;
      scan_cnt <= '0;
      deb_cnt  <= '0;
      row_idx  <= 2'd0;
      key_row  <= 4'b1110;
      pattern  <= 4'hF;
      cand     <= 4'd0;
    end else begin
      case (state)
        SCAN: begin
          if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (one_low(col_s)) begin
              cand    <= {row_idx, low_index(col_s)};
              pattern <= col_s;
              deb_cnt <= '0;
              state   <= CONFIRM;
            end else begin
              row_idx <= row_idx + 2'd1;
              key_row <= row_drive(row_idx + 2'd1);
            end
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        CONFIRM: begin
          if (col_s != pattern) begin
            state   <= SCAN;
            row_idx <= row_idx + 2'd1;
            key_row <= row_drive(row_idx + 2'd1);
          end else if (deb_cnt == DEB_LAST) begin
            state <= HOLD;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (col_s == 4'hF) begin
            deb_cnt <= '0;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          if (col_s != 4'hF) begin
            state <= HOLD;
          end else if (deb_cnt == DEB_LAST) begin
            state    <= SCAN;
            scan_cnt <= '0;
            row_idx  <= 2'd0;
            key_row  <= 4'b1110;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  always_comb begin
    rd_word                     = '0;
    rd_word[CODE_LSB +: 4]      = code;
    rd_word[VALID_BIT]          = valid;
    rd_word[OVR_BIT]            = overrun;
  end

  // A latch beats a same-cycle read clear; overrun is never set without valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      code    <= 4'd0;
      valid   <= 1'b0;
      overrun <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_data <= rd_sel ? rd_word : 32'd0;
      if (latch_now) begin
        code    <= cand;
        valid   <= 1'b1;
        overrun <= valid;
      end else if (rd_sel) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized self-checking bench for keypad_scanner; repeat expectations follow KEYPAD_REPEAT_EN
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int SCAN_CYC = 4;
  localparam int DEB_CYC  = 8;
`ifdef KEYPAD_REPEAT_EN
  localparam int REPEAT_DLY = 40;
  localparam int REPEAT_PER = 16;
`endif
  localparam logic [11:0] KADDR = 12'h010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_ena = 1'b0;
  logic [11:0] dv_addr = '0;
  logic [3:0]  key_col;
  logic [3:0]  key_row;
  logic [31:0] rd_data;

  // Physical keypad: a pressed key pulls its column low only while its row is driven low.
  logic       pressed = 1'b0;
  logic [1:0] prow = 2'd0;
  logic [1:0] pcol = 2'd0;
  logic       direct = 1'b0;
  logic [3:0] col_drv = 4'hF;

  always_comb begin
    key_col = 4'hF;
    if (direct) key_col = col_drv;
    else if (pressed && !key_row[prow]) key_col[pcol] = 1'b0;
  end

  keypad_scanner #(
    .KEYADDR  (KADDR),
    .SCAN_CYC (SCAN_CYC),
    .DEB_CYC  (DEB_CYC)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
`endif
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_ena  (rd_ena),
    .dv_addr (dv_addr),
    .key_col (key_col),
    .key_row (key_row),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Software view of the key word.
  logic       m_valid = 1'b0;
  logic       m_ovr = 1'b0;
  logic [3:0] m_code = 4'd0;

  function automatic logic [31:0] m_word();
    return {22'b0, m_ovr, m_valid, 4'b0, m_code};
  endfunction

  function automatic logic [3:0] drv(input int r);
    logic [3:0] v;
    v = 4'hF;
    v[r[1:0]] = 1'b0;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_read(input logic [11:0] addr, input string tag);
    logic [31:0] exp;
    exp = (addr == KADDR) ? m_word() : 32'h0;
    rd_ena  = 1'b1;
    dv_addr = addr;
    @(negedge clk);
    rd_ena  = 1'b0;
    dv_addr = '0;
    chk(tag, rd_data, exp);
    if (addr == KADDR) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    @(negedge clk);
    chk("rd_idle", rd_data, 32'h0);
  endtask

  // Press key k so it is caught at the end of its row slot; latch lands DEB_CYC cycles later.
  task automatic press(input logic [3:0] k, input bit rd_on_latch);
    int n;
    logic [1:0] r;
    r = k[3:2];
    n = 0;
    while (key_row == drv(r) && n < 64) begin @(negedge clk); n++; end
    prow = r;
    pcol = k[1:0];
    pressed = 1'b1;
    while (key_row != drv(r) && n < 64) begin @(negedge clk); n++; end
    if (key_row != drv(r)) begin
      chk("row_reach", key_row, drv(r));
      pressed = 1'b0;
      return;
    end
    repeat (SCAN_CYC - 1 + DEB_CYC) @(negedge clk);
    if (rd_on_latch) begin
      rd_ena  = 1'b1;
      dv_addr = KADDR;
    end
    @(negedge clk);
    if (rd_on_latch) begin
      rd_ena  = 1'b0;
      dv_addr = '0;
      chk("rd_on_latch", rd_data, m_word());
      m_ovr = m_valid;
    end else begin
      m_ovr = m_ovr | m_valid;
    end
    m_valid = 1'b1;
    m_code  = k;
    @(negedge clk);
    chk("row_frozen", key_row, drv(r));
  endtask

  task automatic release_key(input logic [1:0] r);
    pressed = 1'b0;
    repeat (DEB_CYC + 2) @(negedge clk);
    if (r != 2'd0) chk("rel_hold", key_row, drv(r));
    @(negedge clk);
    chk("rel_scan", key_row, 4'b1110);
  endtask

  task automatic bounce(input logic [3:0] pat, input int len);
    direct  = 1'b1;
    col_drv = pat;
    repeat (len) @(negedge clk);
    col_drv = 4'hF;
    repeat (DEB_CYC + 12) @(negedge clk);
    direct = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [3:0]  k;
    logic [11:0] a;
    int          op;
    int          t0;
    int          offs[$];
    int          exp_offs[$];

    repeat (3) @(negedge clk);
    chk("rst_row", key_row, 4'b1110);
    chk("rst_rd", rd_data, 32'h0);
    rst = 1'b0;
    for (int n = 0; n < 5 * SCAN_CYC; n++) begin
      chk("idle_row", key_row, drv((n / SCAN_CYC) % 4));
      @(negedge clk);
    end
    do_read(KADDR, "idle_read");

    press(4'hA, 1'b0);
    release_key(2'd2);
    do_read(KADDR, "read_a");
    do_read(KADDR, "reread_a");

    bounce(4'b1011, 5);
    do_read(KADDR, "after_bounce");
    bounce(4'b1001, 40);
    do_read(KADDR, "after_multi");

    press(4'h3, 1'b0); release_key(2'd0);
    press(4'hC, 1'b0); release_key(2'd3);
    do_read(KADDR, "overrun_read");
    do_read(KADDR, "overrun_clear");

    press(4'h5, 1'b0); release_key(2'd1);
    do_read(12'h000, "wrong_addr");
    do_read(KADDR, "after_wrong_addr");

    press(4'h9, 1'b0); release_key(2'd2);
    press(4'h6, 1'b1); release_key(2'd1);
    do_read(KADDR, "latch_rd_valid");
    press(4'h7, 1'b1); release_key(2'd1);
    do_read(KADDR, "latch_rd_idle");

    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 4);
      k  = 4'($urandom_range(0, 15));
      case (op)
        0, 1: begin press(k, op == 1); release_key(k[3:2]); end
        2: do_read(KADDR, "rnd_read");
        3: begin
          a = 12'($urandom_range(0, 4095));
          if (a == KADDR) a = 12'h000;
          do_read(a, "rnd_other_addr");
        end
        default: bounce(4'($urandom_range(0, 15)), $urandom_range(1, DEB_CYC - 1));
      endcase
    end
    do_read(KADDR, "rnd_final");

    // Hold key F with a read every cycle and record when valid words appear.
    t0 = -1;
    rd_ena  = 1'b1;
    dv_addr = KADDR;
    @(negedge clk);
    prow = 2'd3;
    pcol = 2'd3;
    pressed = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (rd_data[8]) begin
        if (t0 < 0) t0 = c;
        offs.push_back(c - t0);
        chk("rep_word", rd_data, 32'h0000010F);
      end
      if (t0 >= 0 && c - t0 == 99) pressed = 1'b0;
      if (t0 >= 0 && c - t0 >= 99 + DEB_CYC + 20) break;
    end
    rd_ena  = 1'b0;
    dv_addr = '0;
    pressed = 1'b0;
    exp_offs.push_back(0);
`ifdef KEYPAD_REPEAT_EN
    for (int o = REPEAT_DLY; o < 100; o += REPEAT_PER) exp_offs.push_back(o);
`endif
    chk("rep_count", offs.size(), exp_offs.size());
    for (int i = 0; i < exp_offs.size() && i < offs.size(); i++)
      chk("rep_offset", offs[i], exp_offs[i]);
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_code  = 4'hF;
    repeat (20) @(negedge clk);
    do_read(KADDR, "after_repeat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
